// File: rtl/paint_canvas_ctrl.sv
// Paint canvas engine: framebuffer with a one-cell-per-cycle brush stamper,
// an eraser, a whole-canvas clear and a one-cycle-latency display read port.
module paint_canvas_ctrl #(
  parameter int GRID_W     = 48,
  parameter int GRID_H     = 36,
  parameter int COLOR_BITS = 3,
  parameter int MAX_RADIUS = 2,
  parameter int X_W        = $clog2(GRID_W),
  parameter int Y_W        = $clog2(GRID_H),
  parameter int A_W        = $clog2(GRID_W * GRID_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_W-1:0]        mouse_x,
  input  logic [Y_W-1:0]        mouse_y,
  input  logic                  mouse_click,
  input  logic                  mode,
  input  logic [COLOR_BITS-1:0] color_select,
  input  logic [2:0]            brush_size,
  input  logic                  clear_req,
  input  logic [X_W-1:0]        rd_x,
  input  logic [Y_W-1:0]        rd_y,
  output logic [COLOR_BITS-1:0] rd_color,
  output logic                  busy,
  output logic                  done
);

  // state    | meaning
  // S_IDLE   | waiting for clear_req or a click inside the canvas
  // S_STAMP  | writing one brush offset per cycle, raster order
  // S_CLEAR  | writing 0 to one address per cycle
  typedef enum logic [1:0] {S_IDLE, S_STAMP, S_CLEAR} state_t;

  localparam int              LP_CELLS = GRID_W * GRID_H;
  localparam logic [X_W:0]    LP_GW_X  = (X_W+1)'(GRID_W);
  localparam logic [Y_W:0]    LP_GH_Y  = (Y_W+1)'(GRID_H);
  localparam logic [A_W-1:0]  LP_GW_A  = A_W'(GRID_W);
  localparam logic [A_W-1:0]  LP_LAST  = A_W'(LP_CELLS - 1);
  localparam logic [2:0]      LP_MAXR  = 3'(MAX_RADIUS);

  state_t r_state, w_state_nxt;

  logic [A_W-1:0]          r_cnt;
  logic [X_W-1:0]          r_cx;
  logic [Y_W-1:0]          r_cy;
  logic [COLOR_BITS-1:0]   r_col;
  logic [2:0]              r_rad;
  logic signed [X_W:0]     r_dx;
  logic signed [Y_W:0]     r_dy;
  logic [COLOR_BITS-1:0]   r_rd_color;
  logic [COLOR_BITS-1:0]   r_mem [LP_CELLS];

  logic                    w_click_ok;
  logic [2:0]              w_rad_in;
  logic signed [X_W:0]     w_rx;
  logic signed [Y_W:0]     w_ry;
  logic signed [X_W:0]     w_px;
  logic signed [Y_W:0]     w_py;
  logic                    w_in_canvas;
  logic                    w_stamp_last;
  logic                    w_clear_last;
  logic                    w_we;
  logic [A_W-1:0]          w_waddr;
  logic [COLOR_BITS-1:0]   w_wdata;
  logic                    w_rd_ok;
  logic [A_W-1:0]          w_raddr;

  // Brush geometry and clipping of the current stamp offset
  always_comb begin
    w_click_ok   = mouse_click && ({1'b0, mouse_x} < LP_GW_X) && ({1'b0, mouse_y} < LP_GH_Y);
    w_rad_in     = (brush_size > LP_MAXR) ? LP_MAXR : brush_size;
    w_rx         = signed'((X_W+1)'(r_rad));
    w_ry         = signed'((Y_W+1)'(r_rad));
    w_px         = signed'({1'b0, r_cx}) + r_dx;
    w_py         = signed'({1'b0, r_cy}) + r_dy;
    w_in_canvas  = (w_px >= 0) && (w_px < signed'(LP_GW_X)) &&
                   (w_py >= 0) && (w_py < signed'(LP_GH_Y));
    w_stamp_last = (r_dx == w_rx) && (r_dy == w_ry);
    w_clear_last = (r_cnt == LP_LAST);
    w_rd_ok      = ({1'b0, rd_x} < LP_GW_X) && ({1'b0, rd_y} < LP_GH_Y);
    w_raddr      = A_W'(rd_y) * LP_GW_A + A_W'(rd_x);
  end

  // State register; reset lands in CLEAR so the RAM is initialised
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (clear_req)       w_state_nxt = S_CLEAR;
        else if (w_click_ok) w_state_nxt = S_STAMP;
      end
      S_STAMP: begin
        if (clear_req)         w_state_nxt = S_CLEAR;
        else if (w_stamp_last) w_state_nxt = S_IDLE;
      end
      S_CLEAR: begin
        if (w_clear_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs and RAM write port; an aborted stamp gets no done pulse
  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = 1'b0;
    w_we    = 1'b0;
    w_waddr = r_cnt;
    w_wdata = '0;
    case (r_state)
      S_STAMP: begin
        w_we    = w_in_canvas;
        w_waddr = A_W'(w_py[Y_W-1:0]) * LP_GW_A + A_W'(w_px[X_W-1:0]);
        w_wdata = r_col;
        done    = w_stamp_last && !clear_req;
      end
      S_CLEAR: begin
        w_we = 1'b1;
        done = w_clear_last;
      end
      default: ;
    endcase
  end

  // Stamp parameters latched on a click, offset walk, clear address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_cx  <= '0;
      r_cy  <= '0;
      r_col <= '0;
      r_rad <= '0;
      r_dx  <= '0;
      r_dy  <= '0;
    end else begin
      if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
      else                    r_cnt <= '0;
      if (r_state == S_IDLE && !clear_req && w_click_ok) begin
        r_cx  <= mouse_x;
        r_cy  <= mouse_y;
        r_col <= mode ? '0 : color_select;
        r_rad <= w_rad_in;
        r_dx  <= -signed'((X_W+1)'(w_rad_in));
        r_dy  <= -signed'((Y_W+1)'(w_rad_in));
      end else if (r_state == S_STAMP) begin
        if (r_dx == w_rx) begin
          r_dx <= -w_rx;
          r_dy <= r_dy + 1'b1;
        end else begin
          r_dx <= r_dx + 1'b1;
        end
      end
    end
  end

  // Framebuffer write; contents are initialised by the clear sequence
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Read-first display port, out-of-range coordinates read as empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_rd_color <= '0;
    else if (w_rd_ok) r_rd_color <= r_mem[w_raddr];
    else              r_rd_color <= '0;
  end

  assign rd_color = r_rd_color;

endmodule

// File: doc/paint_canvas_ctrl.md
Name: paint_canvas_ctrl

Overview:
Parametrised paint canvas engine for the VGA paint design: owns the pixel-colour framebuffer, stamps square brushes of selectable radius, erases, and clears the whole canvas. A sequential stamp FSM replaces the wide single-cycle shift-mask update with one RAM write per cycle. The framebuffer is clipped at canvas edges, with no row wrap. The display path reads one cell per request with fixed latency, feeding the colour mapper.

Parameters:
GRID_W, 48, canvas width in cells
GRID_H, 36, canvas height in cells
COLOR_BITS, 3, stored colour width ({R,G,B} one bit each by default)
MAX_RADIUS, 2, largest brush radius; brush_size above this clamps
X_W / Y_W / A_W, derived: clog2(GRID_W) / clog2(GRID_H) / clog2(GRID_W*GRID_H)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
mouse_x  in  X_W  cursor column, canvas-relative
mouse_y  in  Y_W  cursor row, canvas-relative
mouse_click  in  1  level; paint request sampled in IDLE
mode  in  1  0 = paint, 1 = erase (writes 0)
color_select  in  COLOR_BITS  paint colour
brush_size  in  3  requested radius
clear_req  in  1  level; clear whole canvas
rd_x  in  X_W  display read column
rd_y  in  Y_W  display read row
rd_color  out  COLOR_BITS  cell colour, 1-cycle latency
busy  out  1  high whenever state != IDLE
done  out  1  1-cycle pulse on the final write of a stamp or clear

Behaviour:
- Reset (async): state=CLEAR, clear counter=0, busy=1, done=0, rd_color=0. Reset asserted mid-stamp or mid-clear aborts it; the clear restarts from address 0 on release.
- Address = y*GRID_W + x, A_W bits. Cell value 0 = white/empty.
- States: IDLE, STAMP, CLEAR.
- IDLE:
  - clear_req has priority: it moves to CLEAR with counter=0.
  - Otherwise, mouse_click=1 latches cx=mouse_x, cy=mouse_y, col=(mode ? 0 : color_select), r=min(brush_size, MAX_RADIUS), dx=dy=-r, and moves to STAMP.
  - Out-of-canvas cursor (mouse_x>=GRID_W or mouse_y>=GRID_H) is ignored; the block stays IDLE.
- STAMP: one offset per cycle, raster order.
  - dx runs -r..+r; on dx=+r, dx resets to -r and dy increments.
  - Write col at (cx+dx, cy+dy) only when 0<=cx+dx<GRID_W and 0<=cy+dy<GRID_H. Compute with signed arithmetic one bit wider than X_W/Y_W. Clipped offsets consume the cycle without writing.
  - The stamp takes exactly (2r+1)^2 cycles. done pulses on offset (+r,+r); the next state is IDLE.
  - clear_req in STAMP aborts the stamp next cycle and moves to CLEAR (counter=0). No done pulse for the aborted stamp.
- CLEAR: writes 0 to address counter, counter++. Takes GRID_W*GRID_H cycles. done pulses on the last address; the next state is IDLE. clear_req and mouse_click are ignored while in CLEAR.
- mouse_click is ignored in STAMP and CLEAR and is not queued. A click held through completion re-stamps on the first IDLE cycle (continuous drawing).
- Read port:
  - rd_color at cycle t+1 = cell(rd_x, rd_y) sampled at t.
  - Out-of-range rd coordinates return 0.
  - Same-cycle read/write to the same address returns the old data (read-first).
  - Reads continue during STAMP/CLEAR; busy does not block them.
- Framebuffer: inferred single-write, single-read synchronous RAM. Contents are not reset directly; the post-reset CLEAR initialises them.
- Latency: click sampled in IDLE at cycle t -> busy=1 at t+1, writes on t+1..t+(2r+1)^2, busy=0 at t+1+(2r+1)^2.

Test Plan:
- Release rst, hold inputs idle -> busy=1 for exactly 1728 cycles, done pulse on cycle 1728; then reading every cell returns 0.
- brush_size=0, color_select=3'b100, click at (10,10) for one cycle -> busy for 1 cycle; (10,10)=4 and all 8 neighbours=0.
- brush_size=1, click at (0,0) with colour 3'b010 -> busy 9 cycles; only (0,0),(1,0),(0,1),(1,1)=2; (47,0) and (47,35) stay 0, proving no wrap.
- brush_size=7 (clamped to 2), click at (20,20), colour 3'b111 -> busy 25 cycles; 5x5 block (18..22,18..22)=7. Then mode=1, brush_size=0 at (20,20) -> that cell 0, others 7.
- Start radius-2 stamp and assert clear_req on the 3rd stamp cycle -> no done for the stamp; CLEAR runs 1728 cycles; canvas all 0. A click asserted during CLEAR produces no writes.
- Read (5,5) while a stamp writes (5,5) in the same cycle -> rd_color shows the old value, new value on the following read. rd_x=48 -> 0.
